// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared request encodings, master states and region map
package mem_bus_pkg;
  localparam logic [1:0] REQ_FETCH = 2'b00;
  localparam logic [1:0] REQ_READ = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;
  localparam int REGION_BIT = 12;
  localparam logic [12:0] ROM_BASE = 13'h0000;
  localparam logic [12:0] RAM_BASE = 13'h1000;
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_SETUP, WR_STROBE, WR_HOLD} state_t;
endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: address to device select; only RAM accepts writes
module mem_region_decode import mem_bus_pkg::*; #(
  parameter int ADDR_W = 13
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              rom_en,
  output logic              ram_en,
  output logic              is_writable
);
  assign ram_en = addr[REGION_BIT];
  assign rom_en = ~addr[REGION_BIT];
  assign is_writable = addr[REGION_BIT];
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: byte bus initiator for fetch, read and write with registered strobes
module mem_bus_master import mem_bus_pkg::*; #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       instr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] address,
  inout  wire  [7:0]        data,
  output logic              rom_en,
  output logic              ram_en,
  output logic              mem_rd,
  output logic              mem_wr
);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  state_t state;
  logic [2:0] wcnt;
  logic is_fetch, data_oe, dec_rom, dec_ram, dec_wr, last;
  logic [7:0] instr_hi, data_out;
  logic [ADDR_W-1:0] dec_addr;
  // one decoder serves both the accept edge and the RD_HI -> RD_LO step
  assign dec_addr = state == IDLE ? req_addr : address + 1'b1;
  assign last = wcnt == WS;
  assign data = data_oe ? data_out : 'z;
  mem_region_decode #(.ADDR_W(ADDR_W)) u_dec (
    .addr(dec_addr),
    .rom_en(dec_rom),
    .ram_en(dec_ram),
    .is_writable(dec_wr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      is_fetch <= 1'b0;
      data_oe <= 1'b0;
      data_out <= '0;
      instr_hi <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      instr <= '0;
      rd_data <= '0;
      address <= '0;
      rom_en <= 1'b0;
      ram_en <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (req_type == REQ_FETCH || req_type == REQ_READ) begin
            state <= req_type == REQ_FETCH ? RD_HI : RD_LO;
            is_fetch <= req_type == REQ_FETCH;
            address <= req_addr;
            rom_en <= dec_rom;
            ram_en <= dec_ram;
            mem_rd <= 1'b1;
            busy <= 1'b1;
            wcnt <= '0;
          end else if (req_type == REQ_WRITE && dec_wr) begin
            state <= WR_SETUP;
            address <= req_addr;
            rom_en <= dec_rom;
            ram_en <= dec_ram;
            data_out <= wr_data;
            data_oe <= 1'b1;
            busy <= 1'b1;
            wcnt <= '0;
          end else begin
            done <= 1'b1;
            err <= 1'b1;
          end
        end
        RD_HI: if (last) begin
          instr_hi <= data;
          address <= dec_addr;
          rom_en <= dec_rom;
          ram_en <= dec_ram;
          wcnt <= '0;
          state <= RD_LO;
        end else wcnt <= wcnt + 3'd1;
        RD_LO: if (last) begin
          if (is_fetch) instr <= {instr_hi, data};
          else rd_data <= data;
          state <= IDLE;
          done <= 1'b1;
          busy <= 1'b0;
          mem_rd <= 1'b0;
          rom_en <= 1'b0;
          ram_en <= 1'b0;
        end else wcnt <= wcnt + 3'd1;
        WR_SETUP: begin
          state <= WR_STROBE;
          mem_wr <= 1'b1;
        end
        WR_STROBE: if (last) begin
          mem_wr <= 1'b0;
          state <= WR_HOLD;
        end else wcnt <= wcnt + 3'd1;
        WR_HOLD: begin
          state <= IDLE;
          done <= 1'b1;
          busy <= 1'b0;
          rom_en <= 1'b0;
          ram_en <= 1'b0;
          data_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: two masters (0 and 2 wait states) against byte memories and a cycle model
module tb_mem_bus_master;
  import mem_bus_pkg::*;
  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0;
  logic [1:0] req_type = 0;
  logic [12:0] req_addr = 0;
  logic [7:0] wr_data = 0;
  logic busy0, done0, err0, mem_rd0, mem_wr0, rom_en0, ram_en0;
  logic busy1, done1, err1, mem_rd1, mem_wr1, rom_en1, ram_en1;
  logic [15:0] instr0, instr1;
  logic [7:0] rd_data0, rd_data1;
  logic [12:0] address0, address1;
  wire [7:0] data0, data1;
  logic [7:0] mem0 [8192];
  logic [7:0] mem1 [8192];
  int checks = 0, errors = 0, cur = 0;

  always #5 clk = ~clk;

  mem_bus_master #(.WAIT_STATES(0), .ADDR_W(13)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_type(req_type), .req_addr(req_addr),
    .wr_data(wr_data), .busy(busy0), .done(done0), .err(err0), .instr(instr0),
    .rd_data(rd_data0), .address(address0), .data(data0), .rom_en(rom_en0),
    .ram_en(ram_en0), .mem_rd(mem_rd0), .mem_wr(mem_wr0));
  mem_bus_master #(.WAIT_STATES(2), .ADDR_W(13)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_type(req_type), .req_addr(req_addr),
    .wr_data(wr_data), .busy(busy1), .done(done1), .err(err1), .instr(instr1),
    .rd_data(rd_data1), .address(address1), .data(data1), .rom_en(rom_en1),
    .ram_en(ram_en1), .mem_rd(mem_rd1), .mem_wr(mem_wr1));

  // responders drive on reads; with the bus fully idle the bench drives 00 so a stuck master driver collides
  assign data0 = (mem_rd0 && (rom_en0 || ram_en0)) ? mem0[address0] :
                 (!mem_wr0 && !rom_en0 && !ram_en0) ? 8'h00 : 8'hzz;
  assign data1 = (mem_rd1 && (rom_en1 || ram_en1)) ? mem1[address1] :
                 (!mem_wr1 && !rom_en1 && !ram_en1) ? 8'h00 : 8'hzz;
  always @(posedge clk) if (mem_wr0 && ram_en0) mem0[address0] <= data0;
  always @(posedge clk) if (mem_wr1 && ram_en1) mem1[address1] <= data1;

  typedef struct packed {
    logic busy, done, err, rd, wr, rom, ram;
    logic [12:0] addr;
    logic [7:0] data;
    logic [15:0] instr;
    logic [7:0] rdd;
  } exp_t;
  exp_t q[$];
  exp_t o0, o1;
  logic [12:0] maddr [2] = '{13'd0, 13'd0};
  logic [15:0] mi [2] = '{16'd0, 16'd0};
  logic [7:0] mr [2] = '{8'd0, 8'd0};
  assign o0 = {busy0, done0, err0, mem_rd0, mem_wr0, rom_en0, ram_en0, address0, data0, instr0, rd_data0};
  assign o1 = {busy1, done1, err1, mem_rd1, mem_wr1, rom_en1, ram_en1, address1, data1, instr1, rd_data1};

  function automatic exp_t idle(int k);
    return exp_t'({7'b0, maddr[k], 8'h00, mi[k], mr[k]});
  endfunction
  function automatic logic [7:0] mrd(int k, logic [12:0] a);
    return k != 0 ? mem1[a] : mem0[a];
  endfunction
  task automatic push(int k, logic [6:0] f, logic [12:0] a, logic [7:0] d);
    q.push_back(exp_t'({f, a, d, mi[k], mr[k]}));
  endtask

  // expected per-cycle bus picture for one accepted request, flags = busy,done,err,rd,wr,rom,ram
  task automatic model_req(int k, logic [1:0] t, logic [12:0] a, logic [7:0] wd);
    int n;
    logic [12:0] a2;
    logic [7:0] hi, lo;
    n = (k != 0 ? 2 : 0) + 1;
    a2 = a + 13'd1;
    if (t == REQ_FETCH) begin
      hi = mrd(k, a);
      lo = mrd(k, a2);
      repeat (n) push(k, {4'b1001, 1'b0, ~a[12], a[12]}, a, hi);
      repeat (n) push(k, {4'b1001, 1'b0, ~a2[12], a2[12]}, a2, lo);
      mi[k] = {hi, lo};
      maddr[k] = a2;
      push(k, 7'b0100000, a2, 8'h00);
    end else if (t == REQ_READ) begin
      repeat (n) push(k, {4'b1001, 1'b0, ~a[12], a[12]}, a, mrd(k, a));
      mr[k] = mrd(k, a);
      maddr[k] = a;
      push(k, 7'b0100000, a, 8'h00);
    end else if (t == REQ_WRITE && a[12]) begin
      push(k, 7'b1000001, a, wd);
      repeat (n) push(k, 7'b1000101, a, wd);
      push(k, 7'b1000001, a, wd);
      maddr[k] = a;
      push(k, 7'b0100000, a, 8'h00);
    end else push(k, 7'b0110000, maddr[k], 8'h00);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (k == cur && q.size() > 0) e = q.pop_front();
      else e = idle(k);
      checks++;
      if ((k != 0 ? o1 : o0) !== e) begin
        errors++;
        $display("FAIL cycle dut%0d t=%0t got %h required %h", k, $time, k != 0 ? o1 : o0, e);
      end
    end
  end

  task automatic chk(string nm, logic [15:0] got, logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  task automatic issue(int k, logic [1:0] t, logic [12:0] a, logic [7:0] wd);
    int i;
    @(posedge clk);
    #2;
    cur = k;
    req_type = t;
    req_addr = a;
    wr_data = wd;
    if (k != 0) req1 = 1; else req0 = 1;
    @(posedge clk);
    #1;
    model_req(k, t, a, wd);
    #1;
    req0 = 0;
    req1 = 0;
    req_type = ~t;
    req_addr = ~a;
    wr_data = ~wd;
    for (i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL timeout dut%0d got %0d pending required 0", k, q.size());
      q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem0[i] = i[7:0] ^ 8'h3c;
      mem1[i] = i[7:0] ^ 8'h3c;
    end
    mem0[0] = 8'ha0;
    mem0[1] = 8'h20;
    mem0[13'h22] = 8'h62;
    mem0[13'h21] = 8'h01;
    mem0[13'h1fff] = 8'hd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk("reset_instr", instr0, 16'h0000);
    chk("reset_busy", {15'b0, busy0}, 16'h0000);
    chk("reset_addr", {3'b0, address1}, 16'h0000);
    issue(0, REQ_FETCH, 13'h0000, 8'h00);
    chk("fetch_instr", instr0, 16'ha020);
    issue(0, REQ_READ, 13'h0022, 8'h00);
    chk("read_rom", {8'h0, rd_data0}, 16'h0062);
    issue(0, REQ_WRITE, 13'h1001, 8'h01);
    issue(0, REQ_READ, 13'h1001, 8'h00);
    chk("write_read_ws0", {8'h0, rd_data0}, 16'h0001);
    issue(1, REQ_WRITE, 13'h1001, 8'h01);
    issue(1, REQ_READ, 13'h1001, 8'h00);
    chk("write_read_ws2", {8'h0, rd_data1}, 16'h0001);
    issue(0, REQ_FETCH, 13'h1fff, 8'h00);
    chk("fetch_wrap", instr0, 16'hd0a0);
    issue(1, REQ_FETCH, 13'h1fff, 8'h00);
    chk("fetch_wrap_ws2", instr1, 16'hc33c);
    issue(0, REQ_WRITE, 13'h0005, 8'h55);
    chk("rom_untouched", {8'h0, mem0[5]}, 16'h0039);
    issue(0, 2'b11, 13'h1005, 8'h66);
    chk("reserved_no_write", {8'h0, mem0[13'h1005]}, 16'h0039);
    @(posedge clk);
    #2;
    cur = 0;
    req_type = REQ_WRITE;
    req_addr = 13'h1002;
    wr_data = 8'h77;
    req0 = 1;
    @(posedge clk);
    #1 model_req(0, REQ_WRITE, 13'h1002, 8'h77);
    #1 req0 = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("rst_busy", {15'b0, busy0}, 16'h0000);
    chk("rst_mem_wr", {15'b0, mem_wr0}, 16'h0000);
    chk("rst_ram_en", {15'b0, ram_en0}, 16'h0000);
    chk("rst_data_released", {8'h0, data0}, 16'h0000);
    chk("rst_addr", {3'b0, address0}, 16'h0000);
    q.delete();
    maddr = '{13'd0, 13'd0};
    mi = '{16'd0, 16'd0};
    mr = '{8'd0, 8'd0};
    #4 rst_n = 1;
    chk("rst_no_write", {8'h0, mem0[13'h1002]}, 16'h003e);
    issue(0, REQ_READ, 13'h0021, 8'h00);
    chk("read_after_reset", {8'h0, rd_data0}, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
CPU-side initiator for the shared 8-bit byte memory bus. The ROM and data RAM respond on this bus through ADDRESS[12:0], DATA[7:0], a per-device enable, and MEM_RD/MEM_WR.
- Accepts byte READ, byte WRITE and 16-bit instruction FETCH requests from the control unit.
- Decodes the region, sequences the bus strobes and owns the DATA tri-state driver.
- Assembles each fetched instruction from two consecutive bytes, high byte first. Bits [15:13] are the opcode and bits [12:0] the operand address.

Parameters:
- WAIT_STATES, 0, extra cycles MEM_RD/MEM_WR stay asserted beyond the minimum one cycle (0..7).
- ADDR_W, 13, bus address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  1  request strobe; sampled only in IDLE.
- REQ_TYPE  in  2  00 FETCH, 01 READ, 10 WRITE, 11 reserved.
- REQ_ADDR  in  13  byte address.
- WR_DATA  in  8  write byte.
- BUSY  out  1  high in every non-IDLE state.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  pulses with DONE on a rejected request.
- INSTR  out  16  last fetched instruction.
- RD_DATA  out  8  last read byte.
- ADDRESS  out  13  bus address.
- DATA  inout  8  bus data; driven only during write phases, else 8'hzz.
- ROM_EN  out  1  ROM select, ADDRESS[12]==0.
- RAM_EN  out  1  RAM select, ADDRESS[12]==1.
- MEM_RD  out  1  read strobe.
- MEM_WR  out  1  write strobe.

Behaviour:
- All bus outputs are registered. Responders are combinational, so read data is valid while MEM_RD and the enable are high.
- Reset (asynchronous, immediate, also mid-operation):
  - state IDLE; BUSY/DONE/ERR/MEM_RD/MEM_WR/ROM_EN/RAM_EN = 0.
  - ADDRESS = 0, INSTR = 0, RD_DATA = 0, DATA released to z, wait counter = 0.
- States: IDLE, RD_HI, RD_LO, WR_SETUP, WR_STROBE, WR_HOLD.
- IDLE with REQ=1 at an edge:
  - FETCH -> RD_HI at REQ_ADDR.
  - READ -> RD_LO at REQ_ADDR.
  - WRITE to the RAM region -> WR_SETUP.
  - WRITE to the ROM region, or type 11 -> stay IDLE, pulse DONE+ERR next cycle, no bus activity.
- RD_HI / RD_LO:
  - ADDRESS, the matching enable and MEM_RD are held for 1+WAIT_STATES cycles.
  - DATA is sampled at the last edge of that window.
  - RD_HI stores INSTR[15:8], then goes to RD_LO at ADDRESS+1. The increment wraps mod 2^13, so 0x1FFF -> 0x0000, and the enable is re-decoded.
  - RD_LO stores INSTR[7:0] for a FETCH, or RD_DATA for a READ, then goes to IDLE with DONE.
- No idle cycle between RD_HI and RD_LO; MEM_RD stays high across the boundary.
- Write sequence (data is never driven while MEM_RD is high):
  - WR_SETUP: 1 cycle; ADDRESS, RAM_EN, DATA=WR_DATA; MEM_WR=0.
  - WR_STROBE: 1+WAIT_STATES cycles with MEM_WR=1.
  - WR_HOLD: 1 cycle; MEM_WR=0, DATA and ADDRESS still driven.
  - Then IDLE with DONE.
- Enables deassert and DATA goes to z in the cycle DONE is high.
- Latency from the accept edge to DONE high, WAIT_STATES=0: READ 2 cycles, FETCH 3, WRITE 4, rejected 1.
- INSTR and RD_DATA update only at their sample edges and hold otherwise; INSTR changes only after both halves.
- REQ_ADDR, REQ_TYPE and WR_DATA are captured at accept. Changes during BUSY are ignored, as is REQ while BUSY (no queue).
- REQ high in the DONE cycle is accepted at that edge, giving back-to-back operation.
- A bus read returning z/x is captured as-is; no checking is done.

Decomposition:
- Shared package mem_bus_pkg holds:
  - REQ_TYPE encodings (REQ_FETCH, REQ_READ, REQ_WRITE);
  - the state enum;
  - the REGION_BIT=12 constant, and ROM_BASE/RAM_BASE.
- One natural sub-module: mem_region_decode, combinational ADDRESS -> ROM_EN/RAM_EN/is_writable. It is reused by the bus monitor.

Test Plan:
1. Reset, then FETCH 0x0000 with ROM bytes a0,20 (WAIT_STATES=0) -> INSTR=16'ha020 and one DONE pulse 3 cycles after accept. MEM_RD is high for exactly 2 cycles, ADDRESS goes 0x0000 then 0x0001, and DATA is never driven by the master.
2. READ 0x0022 with ROM byte 0x62 -> RD_DATA=8'h62, ROM_EN=1, RAM_EN=0 throughout, DONE 2 cycles after accept.
3. WRITE 0x1001 data 0x01, then READ 0x1001 -> MEM_WR is high for exactly 1 cycle, DATA=0x01 over SETUP..HOLD, and the read returns RD_DATA=0x01. Repeat with WAIT_STATES=2: MEM_WR is high for 3 cycles.
4. FETCH 0x1FFF, RAM[0x1FFF]=0xd0, ROM[0x0000]=0xa0 -> ADDRESS wraps to 0x0000 with the enable switching RAM->ROM, and INSTR=16'hd0a0.
5. WRITE to 0x0005, then REQ_TYPE=11 -> each gives DONE+ERR one cycle after accept, no MEM_WR/MEM_RD and no enable asserted.
6. RST_N low during WR_STROBE -> all strobes and enables drop and DATA goes z without waiting for CLK, with BUSY=0. After release, a READ 0x0021 returns 0x01 normally.
